core_mem_arbiter: RTL and testbench
===================================

// Module: core_mem_arbiter
// PURPOSE
//  Sits directly downstream of the core top: merges the IFU fetch port and the LSU load/store port
//  onto the single memory request/response port. One outstanding transaction at a time.
//  Holds each request in registers until memory accepts it, routes the response to its owner,
//  and produces an error response when memory never answers (watchdog).
// PARAMETERS
//  ADDR_W       32   address width
//  DATA_W       32   data width; wstrb width is DATA_W/8
//  TIMEOUT_CYC  255  cycles spent in REQ+RESP before an error response (>=2, fits 16 bits)
// PORTS
//  clk             in   1         clock
//  rst             in   1         synchronous, active-high reset
//  ifu_req_valid   in   1         fetch request
//  ifu_req_ready   out  1         fetch request accepted this cycle
//  ifu_addr        in   ADDR_W    fetch address
//  ifu_resp_valid  out  1         one-cycle pulse: fetch data valid
//  ifu_resp_data   out  DATA_W    fetched instruction
//  ifu_resp_err    out  1         qualifies ifu_resp_valid: timeout
//  lsu_req_valid   in   1         load/store request
//  lsu_req_ready   out  1         load/store request accepted this cycle
//  lsu_addr        in   ADDR_W    access address
//  lsu_we          in   1         1 = store
//  lsu_wdata       in   DATA_W    store data
//  lsu_wstrb       in   DATA_W/8  byte enables
//  lsu_resp_valid  out  1         one-cycle pulse: load data / store done
//  lsu_resp_data   out  DATA_W    load data (0 for stores)
//  lsu_resp_err    out  1         qualifies lsu_resp_valid: timeout
//  mem_req_valid   out  1         request to memory
//  mem_req_ready   in   1         memory accepts request
//  mem_addr/mem_we/mem_wdata/mem_wstrb  out  ADDR_W/1/DATA_W/DATA_W/8  registered request fields
//  mem_resp_valid  in   1         memory response
//  mem_resp_data   in   DATA_W    memory read data
// BEHAVIOUR
//  - Reset: state IDLE; every output, req register, owner, watchdog = 0.
//  - FSM IDLE -> REQ -> RESP -> IDLE.
//  - IDLE: x_req_ready = x_req_valid & grant(x), combinational; at most one ready high.
//    On handshake latch addr/we/wdata/wstrb (IFU: we=0, wstrb=0) and owner; go to REQ.
//  - REQ: mem_req_valid=1, fields stable. On mem_req_ready go to RESP.
//    If mem_resp_valid coincides with mem_req_ready (zero-latency memory), complete directly to IDLE.
//  - RESP: on mem_resp_valid, return to IDLE.
//  - Response timing: mem_resp_valid in cycle M gives owner resp_valid=1, err=0 in cycle M+1
//    (registered), for exactly one cycle. data = mem_resp_data for loads/fetches, 0 for stores.
//  - Next request: accepted in the same cycle as resp_valid at the earliest
//    (accept -> mem_req_valid = 1 cycle).
//  - Watchdog: clears on accept; increments each cycle in REQ/RESP.
//    On reaching TIMEOUT_CYC: owner resp_valid=1, err=1, data=0; go to IDLE.
//    mem_req_valid drops; a late mem_resp_valid while in IDLE/REQ (without ready) is ignored.
//  - mem_resp_valid outside RESP, and outside the REQ ready cycle, is ignored.
//  - Fixed grant: LSU over IFU when both are valid in IDLE.
//  - Requests held valid while not ready must keep their fields stable (master contract).
//  - rst mid-transaction: abort immediately to IDLE, no response issued; outputs 0 next cycle.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: a last-owner flag (reset = IFU) is updated on every grant.
//    On conflict the master that was NOT last granted wins; no conflict means the sole requester wins.
//  Undefined: fixed LSU priority as above; the flag is absent.
// TESTING
//  1. IFU alone, addr=0x8000_0000, mem ready at once, resp 2 cycles later with 0x0000_0413
//     -> mem_addr=0x8000_0000, we=0; ifu_resp_valid 1 cycle, data 0x0000_0413, err=0.
//  2. Both valid same cycle (IFU 0x100, LSU store 0x200, wdata=0xDEADBEEF, wstrb=0xF)
//     -> LSU granted first (mem_we=1, lsu_resp_data=0); IFU granted after the LSU response.
//     With ARB_ROUND_ROBIN_EN after reset: the LSU still wins first. Second conflict: IFU wins.
//  3. mem_req_ready held 0 for 5 cycles -> mem_req_valid and all fields stable.
//     Then handshake proceeds; the response routes correctly.
//  4. Memory never responds, TIMEOUT_CYC=8 -> owner resp_valid, err=1, data=0 exactly 8 cycles
//     after accept. A later stray mem_resp_valid produces no response.
//  5. Zero-latency memory: ready and resp_valid in same cycle with 0x1234
//     -> resp_valid next cycle with 0x1234; a new request is accepted that cycle.
//  6. rst asserted while in RESP -> next cycle IDLE, all outputs 0, no resp pulse.
//     After rst release the IFU is accepted normally.

Source files
------------

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: merges the IFU fetch port and the LSU load/store port onto a single
// memory request/response port with one transaction outstanding. The request is held in
// registers until memory accepts it. The response goes back to its owner one cycle after
// memory returns it. A watchdog returns an error response if memory never answers.
// Optional feature macro: ARB_ROUND_ROBIN_EN. When it is defined, a conflict is granted to
// the master that was not granted last. When it is undefined, the LSU always wins.
module core_mem_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  // Instruction fetch port
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_W-1:0]     ifu_addr,
  output logic                  ifu_resp_valid,
  output logic [DATA_W-1:0]     ifu_resp_data,
  output logic                  ifu_resp_err,
  // Load/store port
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_W-1:0]     lsu_addr,
  input  logic                  lsu_we,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wstrb,
  output logic                  lsu_resp_valid,
  output logic [DATA_W-1:0]     lsu_resp_data,
  output logic                  lsu_resp_err,
  // Memory port
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_resp_data
);

  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned WdogW = 16;
  // The expiry is registered, so it is flagged in the cycle before the error response.
  // The error response therefore lands exactly TIMEOUT_CYC cycles after accept.
  localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT_CYC - 2);

  localparam logic OwnIfu = 1'b0;
  localparam logic OwnLsu = 1'b1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [StrbW-1:0]    wstrb_q, wstrb_d;
  logic [WdogW-1:0]    wdog_q, wdog_d;

  logic                ifu_resp_valid_q, ifu_resp_valid_d;
  logic [DATA_W-1:0]   ifu_resp_data_q, ifu_resp_data_d;
  logic                ifu_resp_err_q, ifu_resp_err_d;
  logic                lsu_resp_valid_q, lsu_resp_valid_d;
  logic [DATA_W-1:0]   lsu_resp_data_q, lsu_resp_data_d;
  logic                lsu_resp_err_q, lsu_resp_err_d;

  logic                grant_lsu, grant_ifu;
  logic                accept_ok;
  logic                done, expire;
  logic [DATA_W-1:0]   resp_data;

`ifdef ARB_ROUND_ROBIN_EN
  logic                last_q, last_d;

  // Grant selection: on a conflict, the master that was not granted last wins.
  always_comb begin
    grant_lsu = lsu_req_valid;
    if (lsu_req_valid && ifu_req_valid) begin
      grant_lsu = (last_q == OwnIfu);
    end
    grant_ifu = ifu_req_valid && !grant_lsu;
  end

  // Last-owner flag: updated on every grant.
  always_comb begin
    last_d = last_q;
    if (lsu_req_ready) begin
      last_d = OwnLsu;
    end else if (ifu_req_ready) begin
      last_d = OwnIfu;
    end
  end

  // Last-owner register: reset to IFU so that the first conflict goes to the LSU.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= OwnIfu;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Grant selection: fixed priority, the LSU beats the IFU.
  always_comb begin
    grant_lsu = lsu_req_valid;
    grant_ifu = ifu_req_valid && !lsu_req_valid;
  end
`endif

  // Handshakes are possible only in idle. They are masked during reset so that a
  // request is never acknowledged and then lost.
  assign accept_ok     = (state_q == StIdle) && !rst;
  assign lsu_req_ready = accept_ok && grant_lsu;
  assign ifu_req_ready = accept_ok && grant_ifu;

  // FSM next state, request capture and watchdog.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    wdog_d  = wdog_q;
    done    = 1'b0;
    expire  = 1'b0;

    case (state_q)
      StIdle: begin
        if (lsu_req_ready) begin
          owner_d = OwnLsu;
          addr_d  = lsu_addr;
          we_d    = lsu_we;
          wdata_d = lsu_wdata;
          wstrb_d = lsu_wstrb;
          wdog_d  = '0;
          state_d = StReq;
        end else if (ifu_req_ready) begin
          owner_d = OwnIfu;
          addr_d  = ifu_addr;
          we_d    = 1'b0;
          wdata_d = '0;
          wstrb_d = '0;
          wdog_d  = '0;
          state_d = StReq;
        end
      end

      StReq: begin
        wdog_d = wdog_q + WdogW'(1);
        // A zero-latency memory answers in the same cycle it accepts the request.
        if (mem_req_ready && mem_resp_valid) begin
          done    = 1'b1;
          state_d = StIdle;
        end else if (wdog_q == WdogLast) begin
          expire  = 1'b1;
          state_d = StIdle;
        end else if (mem_req_ready) begin
          state_d = StResp;
        end
      end

      StResp: begin
        wdog_d = wdog_q + WdogW'(1);
        // A real answer wins over an expiry in the same cycle.
        if (mem_resp_valid) begin
          done    = 1'b1;
          state_d = StIdle;
        end else if (wdog_q == WdogLast) begin
          expire  = 1'b1;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Response routing: one-cycle pulse to the owner. Data is zero for stores and errors.
  always_comb begin
    ifu_resp_valid_d = 1'b0;
    ifu_resp_data_d  = '0;
    ifu_resp_err_d   = 1'b0;
    lsu_resp_valid_d = 1'b0;
    lsu_resp_data_d  = '0;
    lsu_resp_err_d   = 1'b0;
    resp_data        = (done && !we_q) ? mem_resp_data : '0;

    if (done || expire) begin
      if (owner_q == OwnLsu) begin
        lsu_resp_valid_d = 1'b1;
        lsu_resp_data_d  = resp_data;
        lsu_resp_err_d   = expire;
      end else begin
        ifu_resp_valid_d = 1'b1;
        ifu_resp_data_d  = resp_data;
        ifu_resp_err_d   = expire;
      end
    end
  end

  // State and datapath registers. A synchronous reset aborts any transaction silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      owner_q          <= OwnIfu;
      addr_q           <= '0;
      we_q             <= 1'b0;
      wdata_q          <= '0;
      wstrb_q          <= '0;
      wdog_q           <= '0;
      ifu_resp_valid_q <= 1'b0;
      ifu_resp_data_q  <= '0;
      ifu_resp_err_q   <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      lsu_resp_data_q  <= '0;
      lsu_resp_err_q   <= 1'b0;
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      addr_q           <= addr_d;
      we_q             <= we_d;
      wdata_q          <= wdata_d;
      wstrb_q          <= wstrb_d;
      wdog_q           <= wdog_d;
      ifu_resp_valid_q <= ifu_resp_valid_d;
      ifu_resp_data_q  <= ifu_resp_data_d;
      ifu_resp_err_q   <= ifu_resp_err_d;
      lsu_resp_valid_q <= lsu_resp_valid_d;
      lsu_resp_data_q  <= lsu_resp_data_d;
      lsu_resp_err_q   <= lsu_resp_err_d;
    end
  end

  assign mem_req_valid  = (state_q == StReq);
  assign mem_addr       = addr_q;
  assign mem_we         = we_q;
  assign mem_wdata      = wdata_q;
  assign mem_wstrb      = wstrb_q;

  assign ifu_resp_valid = ifu_resp_valid_q;
  assign ifu_resp_data  = ifu_resp_data_q;
  assign ifu_resp_err   = ifu_resp_err_q;
  assign lsu_resp_valid = lsu_resp_valid_q;
  assign lsu_resp_data  = lsu_resp_data_q;
  assign lsu_resp_err   = lsu_resp_err_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: runs cycle-by-cycle scenarios against hand-computed
// expectations. TIMEOUT_CYC is set to 8 so that the watchdog fires within a short run.
module tb_core_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          ifu_req_valid, ifu_req_ready;
  logic [AW-1:0] ifu_addr;
  logic          ifu_resp_valid, ifu_resp_err;
  logic [DW-1:0] ifu_resp_data;
  logic          lsu_req_valid, lsu_req_ready, lsu_we;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata;
  logic [3:0]    lsu_wstrb;
  logic          lsu_resp_valid, lsu_resp_err;
  logic [DW-1:0] lsu_resp_data;
  logic          mem_req_valid, mem_req_ready, mem_we, mem_resp_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_resp_data;
  logic [3:0]    mem_wstrb;

  int unsigned n_checks;
  int unsigned n_errors;

  core_mem_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_data  (ifu_resp_data),
    .ifu_resp_err   (ifu_resp_err),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_addr       (lsu_addr),
    .lsu_we         (lsu_we),
    .lsu_wdata      (lsu_wdata),
    .lsu_wstrb      (lsu_wstrb),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_data  (lsu_resp_data),
    .lsu_resp_err   (lsu_resp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_req_valid  = 1'b0;
    ifu_addr       = '0;
    lsu_req_valid  = 1'b0;
    lsu_addr       = '0;
    lsu_we         = 1'b0;
    lsu_wdata      = '0;
    lsu_wstrb      = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
  endtask

  // Keeps the run bounded even if the scenario sequence stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_ifu_resp_valid", ifu_resp_valid, 0);
    check("rst_lsu_resp_valid", lsu_resp_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_ifu_ready", ifu_req_ready, 0);

    // 1: the IFU alone, response returned two cycles after accept.
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0000;
    mem_req_ready = 1'b1;
    #1;
    check("t1_ifu_ready", ifu_req_ready, 1);
    check("t1_lsu_ready", lsu_req_ready, 0);
    tick();
    ifu_req_valid = 1'b0;
    #1;
    check("t1_mem_valid", mem_req_valid, 1);
    check("t1_mem_addr", mem_addr, 64'h8000_0000);
    check("t1_mem_we", mem_we, 0);
    tick();
    mem_req_ready = 1'b0;
    #1;
    check("t1_no_early_resp", ifu_resp_valid, 0);
    check("t1_mem_valid_resp", mem_req_valid, 0);
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_0413;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    #1;
    check("t1_resp_valid", ifu_resp_valid, 1);
    check("t1_resp_data", ifu_resp_data, 64'h413);
    check("t1_resp_err", ifu_resp_err, 0);
    check("t1_lsu_quiet", lsu_resp_valid, 0);
    tick();
    #1;
    check("t1_resp_pulse", ifu_resp_valid, 0);

    // 2: a conflict. The LSU store wins first; a second conflict then follows.
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h100;
    lsu_req_valid = 1'b1;
    lsu_we        = 1'b1;
    lsu_addr      = 32'h200;
    lsu_wdata     = 32'hDEAD_BEEF;
    lsu_wstrb     = 4'hF;
    #1;
    check("t2_lsu_ready", lsu_req_ready, 1);
    check("t2_ifu_ready", ifu_req_ready, 0);
    tick();
    lsu_req_valid = 1'b0;
    #1;
    check("t2_mem_we", mem_we, 1);
    check("t2_mem_addr", mem_addr, 64'h200);
    check("t2_mem_wdata", mem_wdata, 64'hDEAD_BEEF);
    check("t2_mem_wstrb", mem_wstrb, 64'hF);
    check("t2_ifu_wait", ifu_req_ready, 0);
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h5555_5555;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    lsu_req_valid  = 1'b1;
    lsu_we         = 1'b0;
    lsu_addr       = 32'h300;
    lsu_wdata      = '0;
    lsu_wstrb      = '0;
    #1;
    check("t2_store_resp_valid", lsu_resp_valid, 1);
    check("t2_store_resp_data", lsu_resp_data, 0);
    check("t2_c2_ifu_ready", ifu_req_ready, RrEn);
    check("t2_c2_lsu_ready", lsu_req_ready, !RrEn);
    tick();
    ifu_req_valid  = !RrEn;
    lsu_req_valid  = RrEn;
    #1;
    check("t2_c2_mem_addr", mem_addr, RrEn ? 64'h100 : 64'h300);
    check("t2_c2_mem_we", mem_we, 0);
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hA5A5_0001;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    #1;
    check("t2_w_ifu_resp", ifu_resp_valid, RrEn);
    check("t2_w_lsu_resp", lsu_resp_valid, !RrEn);
    check("t2_w_data", RrEn ? ifu_resp_data : lsu_resp_data, 64'hA5A5_0001);
    check("t2_l_ready", RrEn ? lsu_req_ready : ifu_req_ready, 1);
    tick();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    #1;
    check("t2_l_mem_addr", mem_addr, RrEn ? 64'h300 : 64'h100);
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0BAD_0002;
    tick();
    clear_inputs();
    #1;
    check("t2_l_ifu_resp", ifu_resp_valid, !RrEn);
    check("t2_l_lsu_resp", lsu_resp_valid, RrEn);
    check("t2_l_data", RrEn ? lsu_resp_data : ifu_resp_data, 64'h0BAD_0002);
    tick();

    // 3: memory holds off for 5 cycles; the request fields must stay stable.
    lsu_req_valid = 1'b1;
    lsu_we        = 1'b0;
    lsu_addr      = 32'h440;
    lsu_wdata     = 32'h1234_5678;
    lsu_wstrb     = 4'h3;
    #1;
    check("t3_lsu_ready", lsu_req_ready, 1);
    tick();
    clear_inputs();
    for (int i = 1; i <= 5; i++) begin
      mem_resp_valid = (i == 2);
      #1;
      check("t3_hold_valid", mem_req_valid, 1);
      check("t3_hold_addr", mem_addr, 64'h440);
      check("t3_hold_wdata", mem_wdata, 64'h1234_5678);
      check("t3_hold_wstrb", mem_wstrb, 64'h3);
      check("t3_hold_we", mem_we, 0);
      check("t3_no_resp", lsu_resp_valid, 0);
      tick();
    end
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hCAFE_F00D;
    #1;
    check("t3_still_valid", mem_req_valid, 1);
    tick();
    clear_inputs();
    #1;
    check("t3_resp_valid", lsu_resp_valid, 1);
    check("t3_resp_data", lsu_resp_data, 64'hCAFE_F00D);
    check("t3_resp_err", lsu_resp_err, 0);
    check("t3_ifu_quiet", ifu_resp_valid, 0);
    tick();

    // 4: memory never accepts; the error response lands 8 cycles after accept.
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h900;
    #1;
    check("t4_ifu_ready", ifu_req_ready, 1);
    tick();
    ifu_req_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      #1;
      check("t4_wait_mem_valid", mem_req_valid, 1);
      check("t4_wait_no_resp", ifu_resp_valid, 0);
      tick();
    end
    #1;
    check("t4_to_valid", ifu_resp_valid, 1);
    check("t4_to_err", ifu_resp_err, 1);
    check("t4_to_data", ifu_resp_data, 0);
    check("t4_to_mem_drop", mem_req_valid, 0);
    check("t4_to_lsu_quiet", lsu_resp_valid, 0);
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h9999;
    #1;
    check("t4_pulse_end", ifu_resp_valid, 0);
    tick();
    mem_resp_valid = 1'b0;
    #1;
    check("t4_stray_ifu", ifu_resp_valid, 0);
    check("t4_stray_lsu", lsu_resp_valid, 0);
    check("t4_idle_mem", mem_req_valid, 0);
    tick();

    // 5: zero-latency memory; the next request is accepted on the response cycle.
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h1000;
    tick();
    ifu_req_valid  = 1'b0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h1234;
    tick();
    clear_inputs();
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h2000;
    #1;
    check("t5_resp_valid", ifu_resp_valid, 1);
    check("t5_resp_data", ifu_resp_data, 64'h1234);
    check("t5_next_accept", lsu_req_ready, 1);
    tick();
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    #1;
    check("t5_next_mem_valid", mem_req_valid, 1);
    check("t5_next_mem_addr", mem_addr, 64'h2000);
    tick();
    mem_req_ready = 1'b0;
    #1;
    check("t6_in_resp", mem_req_valid, 0);

    // 6: reset while in RESP, with a response arriving in the same cycle.
    rst            = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h7777;
    tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    check("t6_lsu_resp", lsu_resp_valid, 0);
    check("t6_ifu_resp", ifu_resp_valid, 0);
    check("t6_mem_valid", mem_req_valid, 0);
    check("t6_mem_addr", mem_addr, 0);
    check("t6_lsu_data", lsu_resp_data, 0);
    tick();
    #1;
    check("t6_lsu_resp_late", lsu_resp_valid, 0);
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h3000;
    #1;
    check("t6_ifu_ready", ifu_req_ready, 1);
    tick();
    ifu_req_valid  = 1'b0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h42;
    #1;
    check("t6_mem_addr_new", mem_addr, 64'h3000);
    tick();
    clear_inputs();
    #1;
    check("t6_resp_valid", ifu_resp_valid, 1);
    check("t6_resp_data", ifu_resp_data, 64'h42);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
